// File: rtl/dwa_scheduler_18.sv
// dwa_scheduler_18: data-weighted-averaging element scheduler for the
// 18-element unary DAC array. Converts a 0..18 element count into an
// 18-bit enable word whose ones start at a rotating pointer.
// Optional macro BIDIR_DWA_EN: alternate rotation direction on every
// accepted DWA sample (forward, reverse, forward, ...).
module dwa_scheduler_18 #(
    parameter int NUM_EL = 18,
    parameter int CW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     code_in,
    input  logic              code_valid,
    input  logic              dwa_en,
    output logic [NUM_EL-1:0] elem_en,
    output logic              out_valid,
    output logic [CW-1:0]     ptr,
    output logic              sat
);

    localparam logic [CW-1:0] NMAX = CW'(NUM_EL);
    localparam logic [CW:0]   L6   = (CW+1)'(NUM_EL);

    logic [CW-1:0]     n;
    logic              sat_c;
    logic [CW:0]       p6, n6, sum6, dif6;
    logic [CW-1:0]     ptr_nxt;
    logic [NUM_EL-1:0] en_nxt;
    logic              dir_rev;

    // clamp the requested count to the array size
    always_comb begin
        sat_c = (code_in > NMAX);
        n     = sat_c ? NMAX : code_in;
    end

    assign p6 = {1'b0, ptr};
    assign n6 = {1'b0, n};

    // next pointer: 6-bit sum/difference reduced mod 18 by one correction step
    always_comb begin
        sum6    = p6 + n6;
        dif6    = p6 - n6;
        ptr_nxt = '0;
        if (dwa_en) begin
            if (dir_rev)
                ptr_nxt = CW'((p6 < n6) ? dif6 + L6 : dif6);
            else
                ptr_nxt = CW'((sum6 >= L6) ? sum6 - L6 : sum6);
        end
    end

    // per element: distance from the pointer along the rotation direction;
    // the element is on when that distance is below the count
    for (genvar i = 0; i < NUM_EL; i++) begin : g_el
        localparam logic [CW:0] IDX = (CW+1)'(i);
        logic [CW:0] off;
        always_comb begin
            if (!dwa_en)
                off = IDX;
            else if (dir_rev)
                off = (p6 > IDX) ? p6 - 6'd1 - IDX : p6 + L6 - 6'd1 - IDX;
            else
                off = (IDX >= p6) ? IDX - p6 : IDX + L6 - p6;
        end
        assign en_nxt[i] = (off < n6);
    end

`ifdef BIDIR_DWA_EN
    // direction flag: toggles per accepted DWA sample, forward in thermometer mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dir_rev <= 1'b0;
        else if (code_valid)
            dir_rev <= dwa_en ? ~dir_rev : 1'b0;
    end
`else
    assign dir_rev = 1'b0;
`endif

    // output registers: update on accepted samples, pulses otherwise low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_en   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            sat       <= 1'b0;
        end else begin
            out_valid <= code_valid;
            sat       <= code_valid & sat_c;
            if (code_valid) begin
                elem_en <= en_nxt;
                ptr     <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dwa_scheduler_18.sv
// Self-checking bench for dwa_scheduler_18: directed steps from the test
// plan followed by randomized samples, all checked against a rotation model.
module tb_dwa_scheduler_18;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  code_in;
    logic        code_valid;
    logic        dwa_en;
    logic [17:0] elem_en;
    logic        out_valid;
    logic [4:0]  ptr;
    logic        sat;

    int checks   = 0;
    int failures = 0;

    // reference state
    int          m_ptr;
    int          m_dir;
    logic [17:0] m_elem;
    logic        m_vld;
    logic        m_sat;

    dwa_scheduler_18 dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .dwa_en(dwa_en), .elem_en(elem_en), .out_valid(out_valid),
        .ptr(ptr), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".elem_en"},   32'(elem_en),   32'(m_elem));
        chk({tag, ".ptr"},       32'(ptr),       32'(m_ptr));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        chk({tag, ".sat"},       32'(sat),       32'(m_sat));
    endtask

    // behavioural model: walk n positions from the pointer, modulo 18
    task automatic model(input int code, input bit vld, input bit en);
        int n;
        m_vld = vld;
        m_sat = 1'b0;
        if (!vld) return;
        n     = (code > 18) ? 18 : code;
        m_sat = (code > 18);
        m_elem = '0;
        if (!en) begin
            for (int k = 0; k < n; k++) m_elem[k] = 1'b1;
            m_ptr = 0;
            m_dir = 0;
        end else if (m_dir == 0) begin
            for (int k = 0; k < n; k++) m_elem[(m_ptr + k) % 18] = 1'b1;
            m_ptr = (m_ptr + n) % 18;
`ifdef BIDIR_DWA_EN
            m_dir = 1;
`endif
        end else begin
            for (int k = 0; k < n; k++) m_elem[(m_ptr - 1 - k + 36) % 18] = 1'b1;
            m_ptr = (m_ptr - n + 18) % 18;
            m_dir = 0;
        end
    endtask

    task automatic step(input string tag, input int code, input bit vld, input bit en);
        logic [31:0] c;
        c = 32'(code);
        @(negedge clk);
        code_in    = c[4:0];
        code_valid = vld;
        dwa_en     = en;
        @(posedge clk);
        #1;
        model(code, vld, en);
        chk_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        code_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0; m_dir = 0; m_elem = '0; m_vld = 0; m_sat = 0;
    endtask

    initial begin
        int code;
        rst = 1'b1; code_in = '0; code_valid = 1'b0; dwa_en = 1'b1;
        m_ptr = 0; m_dir = 0; m_elem = '0; m_vld = 0; m_sat = 0;
        #12;
        chk_all("reset");
        rst = 1'b0;

        // two back-to-back samples
        step("s5", 5, 1, 1);
        chk("s5.const", 32'(elem_en), 32'h0001F);
        step("s4", 4, 1, 1);
`ifndef BIDIR_DWA_EN
        chk("s4.const", 32'(elem_en), 32'h001E0);
        chk("s4.ptr",   32'(ptr),     32'd9);
`else
        chk("s3rev.pre", 32'(ptr), 32'd1);
        do_reset();
        step("b5", 5, 1, 1);
        step("b3", 3, 1, 1);
        chk("b3.const", 32'(elem_en), 32'h0001C);
        chk("b3.ptr",   32'(ptr),     32'd2);
        step("b4", 4, 1, 1);
        chk("b4.const", 32'(elem_en), 32'h0003C);
        chk("b4.ptr",   32'(ptr),     32'd6);
`endif

        // wrap from bit 17 to bit 0
        do_reset();
        step("w9", 9, 1, 1);
        step("w6", 6, 1, 1);
        step("wrap", 6, 1, 1);
`ifndef BIDIR_DWA_EN
        chk("wrap.const", 32'(elem_en), 32'h38007);
        chk("wrap.ptr",   32'(ptr),     32'd3);
`endif

        // full count, zero count, saturation, thermometer mode, idle hold
        step("to7", 4, 1, 1);
        step("full", 18, 1, 1);
        chk("full.const", 32'(elem_en), 32'h3FFFF);
        step("zero", 0, 1, 1);
        chk("zero.const", 32'(elem_en), 32'h0);
        step("sat", 25, 1, 1);
        chk("sat.pulse", 32'(sat), 32'd1);
        step("sat.clear", 7, 0, 1);
        step("to11", 4, 1, 1);
        step("therm", 3, 1, 0);
        chk("therm.const", 32'(elem_en), 32'h7);
        chk("therm.ptr",   32'(ptr),     32'd0);
        step("idle1", 12, 0, 1);
        step("idle2", 30, 0, 0);

        // asynchronous reset mid-stream
        do_reset();
        step("r13", 13, 1, 1);
        @(negedge clk);
        code_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_ptr = 0; m_dir = 0; m_elem = '0; m_vld = 0; m_sat = 0;
        chk_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 2, 1, 1);
        chk("post_rst.const", 32'(elem_en), 32'h3);

        // randomized samples
        for (int i = 0; i < 400; i++) begin
            code = ($urandom_range(0, 7) == 0) ? int'($urandom_range(19, 31))
                                               : int'($urandom_range(0, 18));
            step("rand", code, $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
